// File: rtl/bomb_request.sv
// bomb_request: per-player bomb-button to validated placement request,
// with occupancy/board/game-over checks, tie arbitration and tick-based cooldown.
`default_nettype none

module bomb_request #(
  parameter int COOLDOWN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bombTick,
  input  logic         btnA,
  input  logic         btnB,
  input  logic [3:0]   playerAx,
  input  logic [3:0]   playerAy,
  input  logic [3:0]   playerBx,
  input  logic [3:0]   playerBy,
  input  logic [99:0]  i_curBombMap_0,
  input  logic [99:0]  i_curBombMap_1,
  input  logic [1:0]   game_state,
  output logic [3:0]   bombA_x,
  output logic [3:0]   bombA_y,
  output logic [3:0]   bombB_x,
  output logic [3:0]   bombB_y,
  output logic         bombA_v,
  output logic         bombB_v,
  output logic         o_rejectA,
  output logic         o_rejectB
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_COOL    = 2'd2;
  localparam logic [3:0] CD        = 4'(COOLDOWN);

  logic       btn_a_q, btn_b_q, press_a, press_b;
  logic [1:0] state_a, state_a_n, state_b, state_b_n;
  logic [3:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic       acc_a, acc_b, rej_a_n, rej_b_n;
  logic       running, tie, ok_a, ok_b;

  // Cell (x,y) lives at bit 10*x+y; off-board cells are never placeable.
  function automatic logic place_ok(input logic [3:0] x, input logic [3:0] y,
                                    input logic [99:0] m0, input logic [99:0] m1);
    logic [6:0] idx;
    idx = 7'd10 * {3'd0, x} + {3'd0, y};
    if (x < 4'd1 || x > 4'd8 || y < 4'd1 || y > 4'd8) return 1'b0;
    return !(m0[idx] | m1[idx]);
  endfunction

  assign running = (game_state == 2'd0);
  assign ok_a    = place_ok(playerAx, playerAy, i_curBombMap_0, i_curBombMap_1);
  assign ok_b    = place_ok(playerBx, playerBy, i_curBombMap_0, i_curBombMap_1);
  assign tie     = (state_a == S_PENDING) && (state_b == S_PENDING) &&
                   (bombA_x == bombB_x) && (bombA_y == bombB_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_a_q   <= 1'b0;
      btn_b_q   <= 1'b0;
      press_a   <= 1'b0;
      press_b   <= 1'b0;
      state_a   <= S_IDLE;
      state_b   <= S_IDLE;
      cnt_a     <= 4'd0;
      cnt_b     <= 4'd0;
      bombA_x   <= 4'd0;
      bombA_y   <= 4'd0;
      bombB_x   <= 4'd0;
      bombB_y   <= 4'd0;
      o_rejectA <= 1'b0;
      o_rejectB <= 1'b0;
    end else begin
      btn_a_q   <= btnA;
      btn_b_q   <= btnB;
      press_a   <= btnA & ~btn_a_q;
      press_b   <= btnB & ~btn_b_q;
      state_a   <= state_a_n;
      state_b   <= state_b_n;
      cnt_a     <= cnt_a_n;
      cnt_b     <= cnt_b_n;
      o_rejectA <= rej_a_n;
      o_rejectB <= rej_b_n;
      if (acc_a) begin
        bombA_x <= playerAx;
        bombA_y <= playerAy;
      end
      if (acc_b) begin
        bombB_x <= playerBx;
        bombB_y <= playerBy;
      end
    end
  end

  always_comb begin
    state_a_n = state_a;
    cnt_a_n   = cnt_a;
    acc_a     = 1'b0;
    rej_a_n   = 1'b0;
    if (!running) begin
      state_a_n = S_IDLE;
      cnt_a_n   = 4'd0;
    end else begin
      case (state_a)
        S_IDLE: if (press_a) begin
          if (ok_a) begin
            acc_a     = 1'b1;
            state_a_n = S_PENDING;
          end else begin
            rej_a_n = 1'b1;
          end
        end
        S_PENDING: if (bombTick) begin
          state_a_n = (CD == 4'd0) ? S_IDLE : S_COOL;
          cnt_a_n   = CD;
        end
        S_COOL: begin
          rej_a_n = press_a;
          if (bombTick) begin
            if (cnt_a <= 4'd1) begin
              state_a_n = S_IDLE;
              cnt_a_n   = 4'd0;
            end else begin
              cnt_a_n = cnt_a - 4'd1;
            end
          end
        end
        default: state_a_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_b_n = state_b;
    cnt_b_n   = cnt_b;
    acc_b     = 1'b0;
    rej_b_n   = 1'b0;
    if (!running) begin
      state_b_n = S_IDLE;
      cnt_b_n   = 4'd0;
    end else begin
      case (state_b)
        S_IDLE: if (press_b) begin
          if (ok_b) begin
            acc_b     = 1'b1;
            state_b_n = S_PENDING;
          end else begin
            rej_b_n = 1'b1;
          end
        end
        S_PENDING: if (bombTick) begin
          // Losing a same-cell tie drops B's request without any cooldown.
          if (tie) begin
            state_b_n = S_IDLE;
            rej_b_n   = 1'b1;
          end else begin
            state_b_n = (CD == 4'd0) ? S_IDLE : S_COOL;
            cnt_b_n   = CD;
          end
        end
        S_COOL: begin
          rej_b_n = press_b;
          if (bombTick) begin
            if (cnt_b <= 4'd1) begin
              state_b_n = S_IDLE;
              cnt_b_n   = 4'd0;
            end else begin
              cnt_b_n = cnt_b - 4'd1;
            end
          end
        end
        default: state_b_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bombA_v = (state_a == S_PENDING) && running;
    bombB_v = (state_b == S_PENDING) && running && !(tie && bombTick);
  end

endmodule

`default_nettype wire

// File: tb/tb_bomb_request.sv
// Directed bench for bomb_request with an expectation queue checked after each step.
`default_nettype none

module tb_bomb_request;

  logic        clk = 1'b0;
  logic        rst, bombTick, btnA, btnB;
  logic [3:0]  playerAx, playerAy, playerBx, playerBy;
  logic [99:0] map0, map1;
  logic [1:0]  game_state;
  logic [3:0]  bombA_x, bombA_y, bombB_x, bombB_y;
  logic        bombA_v, bombB_v, o_rejectA, o_rejectB;

  int checks = 0;
  int errors = 0;
  int place_cnt = 0;

  string      tag_q[$];
  int         sig_q[$];
  logic [3:0] val_q[$];

  localparam int VA = 0, VB = 1, AX = 2, AY = 3, RA = 4, RB = 5, BX = 6, BY = 7, PC = 8;

  bomb_request #(.COOLDOWN(2)) dut (
    .clk(clk), .rst(rst), .bombTick(bombTick), .btnA(btnA), .btnB(btnB),
    .playerAx(playerAx), .playerAy(playerAy), .playerBx(playerBx), .playerBy(playerBy),
    .i_curBombMap_0(map0), .i_curBombMap_1(map1), .game_state(game_state),
    .bombA_x(bombA_x), .bombA_y(bombA_y), .bombB_x(bombB_x), .bombB_y(bombB_y),
    .bombA_v(bombA_v), .bombB_v(bombB_v), .o_rejectA(o_rejectA), .o_rejectB(o_rejectB)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] observe(input int sig);
    case (sig)
      VA: return {3'd0, bombA_v};
      VB: return {3'd0, bombB_v};
      AX: return bombA_x;
      AY: return bombA_y;
      RA: return {3'd0, o_rejectA};
      RB: return {3'd0, o_rejectB};
      BX: return bombB_x;
      BY: return bombB_y;
      default: return 4'(place_cnt);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_val(input string tag, input int sig, input logic [3:0] val);
    tag_q.push_back(tag);
    sig_q.push_back(sig);
    val_q.push_back(val);
  endtask

  task automatic check();
    string t;
    int s;
    logic [3:0] v, o;
    #1;
    while (sig_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sig_q.pop_front();
      v = val_q.pop_front();
      o = observe(s);
      checks++;
      assert (o === v) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", t, o, v);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bombTick = 1'b0; btnA = 1'b0; btnB = 1'b0;
    playerAx = 4'd3; playerAy = 4'd4; playerBx = 4'd1; playerBy = 4'd1;
    map0 = '0; map1 = '0; game_state = 2'd0;

    // Reset state
    step(); step();
    expect_val("rst_va", VA, 0); expect_val("rst_vb", VB, 0);
    expect_val("rst_ax", AX, 0); expect_val("rst_ay", AY, 0);
    expect_val("rst_bx", BX, 0); expect_val("rst_by", BY, 0);
    expect_val("rst_ra", RA, 0); expect_val("rst_rb", RB, 0);
    check();
    rst = 1'b0;

    // Basic placement at (3,4), tick five cycles later
    btnA = 1'b1;
    step();
    expect_val("lat_va0", VA, 0); check();
    step();
    btnA = 1'b0;
    expect_val("pend_va", VA, 1); expect_val("pend_ax", AX, 3); expect_val("pend_ay", AY, 4);
    check();
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val("hold_va", VA, 1); check();
    end
    bombTick = 1'b1;
    expect_val("tick_va", VA, 1); expect_val("tick_ax", AX, 3); check();
    step();
    bombTick = 1'b0;
    expect_val("post_tick_va", VA, 0); check();

    // Cooldown: presses before two ticks are rejected
    btnA = 1'b1;
    step(); step();
    btnA = 1'b0;
    expect_val("cool_ra1", RA, 1); expect_val("cool_va1", VA, 0); check();
    step();
    expect_val("cool_ra_once", RA, 0); check();
    bombTick = 1'b1; step(); bombTick = 1'b0;
    btnA = 1'b1;
    step(); step();
    btnA = 1'b0;
    expect_val("cool_ra2", RA, 1); expect_val("cool_va2", VA, 0); check();
    bombTick = 1'b1; step(); bombTick = 1'b0;
    btnA = 1'b1;
    step(); step();
    btnA = 1'b0;
    expect_val("after_cool_va", VA, 1); expect_val("after_cool_ra", RA, 0); check();

    // Occupied cell for B, off-board cell for A
    do_reset();
    map0[55] = 1'b1;
    playerBx = 4'd5; playerBy = 4'd5; playerAx = 4'd9; playerAy = 4'd4;
    btnA = 1'b1; btnB = 1'b1;
    step(); step();
    btnA = 1'b0; btnB = 1'b0;
    expect_val("occ_rb", RB, 1); expect_val("occ_vb", VB, 0);
    expect_val("offb_ra", RA, 1); expect_val("offb_va", VA, 0);
    check();
    step();
    expect_val("occ_rb_once", RB, 0); expect_val("occ_vb_later", VB, 0); check();
    map0 = '0;

    // Tie on (2,7)
    do_reset();
    playerAx = 4'd2; playerAy = 4'd7; playerBx = 4'd2; playerBy = 4'd7;
    btnA = 1'b1; btnB = 1'b1;
    step(); step();
    btnA = 1'b0; btnB = 1'b0;
    expect_val("tie_pre_va", VA, 1); expect_val("tie_pre_vb", VB, 1); check();
    bombTick = 1'b1;
    expect_val("tie_va", VA, 1); expect_val("tie_vb", VB, 0);
    expect_val("tie_bx", BX, 2); expect_val("tie_by", BY, 7);
    check();
    step();
    bombTick = 1'b0;
    expect_val("tie_rb", RB, 1); expect_val("tie_ra", RA, 0); check();
    btnB = 1'b1;
    step(); step();
    btnB = 1'b0;
    expect_val("tie_b_nocool_vb", VB, 1); expect_val("tie_b_nocool_rb", RB, 0); check();

    // Tick coincident with the press is not consumed; then game over
    do_reset();
    playerAx = 4'd3; playerAy = 4'd4;
    btnA = 1'b1;
    step();
    bombTick = 1'b1;
    step();
    bombTick = 1'b0; btnA = 1'b0;
    expect_val("same_tick_va", VA, 1); check();
    step();
    expect_val("same_tick_hold_va", VA, 1); check();
    game_state = 2'd2;
    expect_val("go_va_drop", VA, 0); check();
    step();
    game_state = 2'd0;
    expect_val("go_idle_va", VA, 0); check();
    game_state = 2'd2;
    btnA = 1'b1;
    step(); step();
    btnA = 1'b0;
    expect_val("go_press_va", VA, 0); check();
    game_state = 2'd0;
    step();
    expect_val("go_after_va", VA, 0); check();

    // Held button over ten ticks yields one placement
    do_reset();
    btnA = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); step(); step();
      bombTick = 1'b1;
      #1;
      if (bombA_v) place_cnt++;
      step();
      bombTick = 1'b0;
    end
    expect_val("held_one_place", PC, 1); check();

    // Reset in the middle of PENDING
    btnA = 1'b0;
    step();
    btnA = 1'b1;
    step(); step();
    expect_val("rst_pend_va", VA, 1); check();
    rst = 1'b1;
    step();
    expect_val("rst_mid_va", VA, 0); expect_val("rst_mid_ax", AX, 0);
    expect_val("rst_mid_ay", AY, 0); expect_val("rst_mid_ra", RA, 0);
    check();
    rst = 1'b0; btnA = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
